// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU/PC mux selects and the packed control vector driven into the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode and mem_ready in, control strobes out.
// Handshake: a memory access is requested for as long as the FSM sits in FETCH/MEMRD/MEMWR
// and completes on the first cycle mem_ready=1; there is no abort, the request holds until then.
interface mips_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0] op;
  logic       mem_ready;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       memwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal_op;
  state_t     dbg_state;

  modport master (
    input  op, mem_ready,
    output iord, irwrite, pcwrite, branch, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, dbg_state
  );

  modport slave (
    output op, mem_ready,
    input  iord, irwrite, pcwrite, branch, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, dbg_state
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore control decode: current state (plus mem_ready for the memory-completion
// strobes) to the datapath control vector. Unreachable encodings drive all zeros.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = ALUSRCB_FOUR;
        // IR load and PC+4 only land in the cycle memory returns the word
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE:  ctrl.alusrcb = ALUSRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD:   ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state sequencing and the sticky
// illegal-opcode flag; control outputs come from mips_ctrl_outdec.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic       clk,
  input logic       reset,
  mips_ctrl_if.master bus
);

  state_t state;
  logic   illegal_op;
  ctrl_t  dec;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                state      <= S_TRAP;
                illegal_op <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_MEMADR:  state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_TRAP:    state <= S_TRAP;
        default:   state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (dec)
  );

  // Reset forces the strobes low immediately, without waiting for a clock edge
  assign ctrl = reset ? dec : '0;

  assign bus.iord       = ctrl.iord;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.branch     = ctrl.branch;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regdst     = ctrl.regdst;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.aluop      = ctrl.aluop;
  assign bus.instr_done = ctrl.instr_done;
  assign bus.illegal_op = illegal_op;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for mips_multicycle_ctrl: each step queues the expected
// {state, illegal_op, controls} word and compares it against the DUT at the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int W = 21;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset0 = 1'b0;

  mips_ctrl_if bus ();
  mips_ctrl_if bus0 ();

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0.master)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // control word order: iord irwrite pcwrite branch memwrite memtoreg regdst regwrite
  //                     alusrca alusrcb[2] pcsrc[2] aluop[2] instr_done
  function automatic logic [15:0] c(input logic iord, irw, pcw, br, mw, m2r, rd, rw, asa,
                                    input logic [1:0] asb, pcs, aop, input logic done);
    return {iord, irw, pcw, br, mw, m2r, rd, rw, asa, asb, pcs, aop, done};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return c(0, mr, mr, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [15:0] e_memwr(input logic mr);
    return c(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, mr);
  endfunction

  logic [15:0] e_zero, e_decode, e_memadr, e_memrd, e_memwb, e_exec, e_aluwb;
  logic [15:0] e_branch, e_addiex, e_addiwb, e_jump;

  initial begin
    e_zero   = '0;
    e_decode = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    e_memadr = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    e_memrd  = c(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_memwb  = c(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_exec   = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0);
    e_aluwb  = c(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_branch = c(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1);
    e_addiex = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    e_addiwb = c(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_jump   = c(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1);
  end

  function automatic logic [W-1:0] obs_main();
    return {4'(bus.dbg_state), bus.illegal_op, bus.iord, bus.irwrite, bus.pcwrite, bus.branch,
            bus.memwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
            bus.pcsrc, bus.aluop, bus.instr_done};
  endfunction

  function automatic logic [W-1:0] obs_alt();
    return {4'(bus0.dbg_state), bus0.illegal_op, bus0.iord, bus0.irwrite, bus0.pcwrite,
            bus0.branch, bus0.memwrite, bus0.memtoreg, bus0.regdst, bus0.regwrite,
            bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.aluop, bus0.instr_done};
  endfunction

  // driver/scoreboard step: one clock cycle; inputs set before the call apply to it
  task automatic step(input int which, input state_t s, input logic il,
                      input logic [15:0] v, input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    exp_q.push_back({4'(s), il, v});
    @(negedge clk);
    obs   = (which == 0) ? obs_main() : obs_alt();
    exp_v = exp_q.pop_front();
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input state_t s, input logic [15:0] v, input string tag);
    step(0, s, 1'b0, v, tag);
  endtask

  initial begin
    bus.op = OP_RTYPE;  bus.mem_ready = 1'b1;
    bus0.op = 6'b111111; bus0.mem_ready = 1'b1;

    // reset held three cycles: all strobes low
    for (int i = 0; i < 3; i++) run(S_FETCH, e_zero, "reset");
    reset = 1'b1;

    // R-type, 4 cycles
    run(S_FETCH, e_fetch(1), "r_fetch");
    run(S_DECODE, e_decode, "r_decode");
    run(S_EXECUTE, e_exec, "r_execute");
    run(S_ALUWB, e_aluwb, "r_aluwb");

    // LW with slow fetch (2 waits) and slow read (3 waits), 10 cycles
    bus.op = OP_LW; bus.mem_ready = 1'b0;
    run(S_FETCH, e_fetch(0), "lw_fetch_wait");
    run(S_FETCH, e_fetch(0), "lw_fetch_wait");
    bus.mem_ready = 1'b1;
    run(S_FETCH, e_fetch(1), "lw_fetch");
    run(S_DECODE, e_decode, "lw_decode");
    run(S_MEMADR, e_memadr, "lw_memadr");
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) run(S_MEMRD, e_memrd, "lw_memrd_wait");
    bus.mem_ready = 1'b1;
    run(S_MEMRD, e_memrd, "lw_memrd");
    run(S_MEMWB, e_memwb, "lw_memwb");

    // SW with 4 wait cycles on the write
    bus.op = OP_SW;
    run(S_FETCH, e_fetch(1), "sw_fetch");
    run(S_DECODE, e_decode, "sw_decode");
    run(S_MEMADR, e_memadr, "sw_memadr");
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) run(S_MEMWR, e_memwr(0), "sw_memwr_wait");
    bus.mem_ready = 1'b1;
    run(S_MEMWR, e_memwr(1), "sw_memwr");

    // BEQ and J, 3 cycles each
    bus.op = OP_BEQ;
    run(S_FETCH, e_fetch(1), "beq_fetch");
    run(S_DECODE, e_decode, "beq_decode");
    run(S_BRANCH, e_branch, "beq_branch");
    bus.op = OP_J;
    run(S_FETCH, e_fetch(1), "j_fetch");
    run(S_DECODE, e_decode, "j_decode");
    run(S_JUMP, e_jump, "j_jump");

    // ADDI with mem_ready low outside memory states: must not stall or alter outputs
    bus.op = OP_ADDI;
    run(S_FETCH, e_fetch(1), "addi_fetch");
    bus.mem_ready = 1'b0;
    run(S_DECODE, e_decode, "addi_decode");
    run(S_ADDIEX, e_addiex, "addi_ex");
    run(S_ADDIWB, e_addiwb, "addi_wb");
    bus.mem_ready = 1'b1;

    // reset asserted on entry to MEMADR
    bus.op = OP_LW;
    run(S_FETCH, e_fetch(1), "rst1_fetch");
    run(S_DECODE, e_decode, "rst1_decode");
    reset = 1'b0;
    run(S_FETCH, e_zero, "rst_in_memadr");
    reset = 1'b1;
    run(S_FETCH, e_fetch(1), "rst1_resume");

    // reset asserted while a write is stalled in MEMWR
    bus.op = OP_SW;
    run(S_DECODE, e_decode, "rst2_decode");
    run(S_MEMADR, e_memadr, "rst2_memadr");
    bus.mem_ready = 1'b0;
    run(S_MEMWR, e_memwr(0), "rst2_memwr");
    reset = 1'b0;
    run(S_FETCH, e_zero, "rst_in_memwr");
    reset = 1'b1;
    run(S_FETCH, e_fetch(0), "rst2_resume_wait");
    bus.mem_ready = 1'b1;
    run(S_FETCH, e_fetch(1), "rst2_resume");

    // illegal opcode -> sticky TRAP
    bus.op = 6'b111111;
    run(S_DECODE, e_decode, "ill_decode");
    step(0, S_TRAP, 1'b1, e_zero, "trap");
    bus.mem_ready = 1'b0;
    bus.op = OP_RTYPE;
    step(0, S_TRAP, 1'b1, e_zero, "trap_sticky");
    bus.mem_ready = 1'b1;
    step(0, S_TRAP, 1'b1, e_zero, "trap_sticky");
    reset = 1'b0;
    run(S_FETCH, e_zero, "trap_reset");
    reset = 1'b1;
    run(S_FETCH, e_fetch(1), "trap_recover");

    // TRAP_ON_ILLEGAL=0 instance: illegal opcode behaves as a NOP
    step(1, S_FETCH, 1'b0, e_zero, "nop_reset");
    reset0 = 1'b1;
    step(1, S_FETCH, 1'b0, e_fetch(1), "nop_fetch");
    step(1, S_DECODE, 1'b0, e_decode, "nop_decode");
    step(1, S_FETCH, 1'b0, e_fetch(1), "nop_back_fetch");
    step(1, S_DECODE, 1'b0, e_decode, "nop_decode2");

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
